// File: rtl/sram_port_arbiter_if.sv
// Request/response bundle between the two requesters, the arbiter and the SRAM macro.
interface sram_port_arbiter_if #(
  parameter int unsigned AWIDTH = 8,
  parameter int unsigned DWIDTH = 32
);
  logic [1:0]          wbctrl_mem_op;
  logic [AWIDTH-1:0]   wbctrl_mem_addr;
  logic [DWIDTH-1:0]   wbctrl_mem_data;
  logic                mem_opdone;
  logic [DWIDTH-1:0]   sram_data;
  logic [1:0]          core_mem_op;
  logic [AWIDTH-1:0]   core_mem_addr;
  logic [DWIDTH-1:0]   core_mem_data;
  logic                core_mem_opdone;
  logic [DWIDTH-1:0]   core_sram_data;
  logic                busy;
  logic                sram_csb0;
  logic                sram_web0;
  logic [DWIDTH/8-1:0] sram_wmask0;
  logic [AWIDTH-1:0]   sram_addr0;
  logic [DWIDTH-1:0]   sram_din0;
  logic [DWIDTH-1:0]   sram_dout0;

  modport master (
    output wbctrl_mem_op, wbctrl_mem_addr, wbctrl_mem_data,
    output core_mem_op, core_mem_addr, core_mem_data,
    output sram_dout0,
    input  mem_opdone, sram_data, core_mem_opdone, core_sram_data, busy,
    input  sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0
  );

  modport slave (
    input  wbctrl_mem_op, wbctrl_mem_addr, wbctrl_mem_data,
    input  core_mem_op, core_mem_addr, core_mem_data,
    input  sram_dout0,
    output mem_opdone, sram_data, core_mem_opdone, core_sram_data, busy,
    output sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter between the Wishbone controller and the compute core for one
// single-port SRAM; one access at a time, registered strobes, opdone pulse per requester.
module sram_port_arbiter #(
  parameter int unsigned AWIDTH       = 8,
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input logic             clk,
  input logic             reset,
  sram_port_arbiter_if.slave bus
);
  localparam int unsigned MASK_W = DWIDTH / 8;
  localparam int unsigned CNT_W  = 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;      // 0: Wishbone side, 1: core side
  logic                is_write_q, is_write_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                lock_wb_q, lock_wb_d;
  logic                lock_core_q, lock_core_d;
  logic                rr_q, rr_d;
  logic                csb_q, csb_d;
  logic                web_q, web_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   din_q, din_d;
  logic                wb_done_q, wb_done_d;
  logic                core_done_q, core_done_d;
  logic [DWIDTH-1:0]   wb_rdata_q, wb_rdata_d;
  logic [DWIDTH-1:0]   core_rdata_q, core_rdata_d;
  logic                busy_q, busy_d;

  logic                wb_pend, core_pend, sel, sel_write;
  logic [AWIDTH-1:0]   sel_addr;
  logic [DWIDTH-1:0]   sel_data;

  // State and every output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      is_write_q   <= 1'b0;
      cnt_q        <= '0;
      lock_wb_q    <= 1'b0;
      lock_core_q  <= 1'b0;
      rr_q         <= 1'b0;
      csb_q        <= 1'b1;
      web_q        <= 1'b1;
      wmask_q      <= '0;
      addr_q       <= '0;
      din_q        <= '0;
      wb_done_q    <= 1'b0;
      core_done_q  <= 1'b0;
      wb_rdata_q   <= '0;
      core_rdata_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      is_write_q   <= is_write_d;
      cnt_q        <= cnt_d;
      lock_wb_q    <= lock_wb_d;
      lock_core_q  <= lock_core_d;
      rr_q         <= rr_d;
      csb_q        <= csb_d;
      web_q        <= web_d;
      wmask_q      <= wmask_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      wb_done_q    <= wb_done_d;
      core_done_q  <= core_done_d;
      wb_rdata_q   <= wb_rdata_d;
      core_rdata_q <= core_rdata_d;
      busy_q       <= busy_d;
    end
  end

  // Op bit 0 distinguishes read/write (01/11) from none/reserved (00/10)
  assign wb_pend   = bus.wbctrl_mem_op[0] && !lock_wb_q;
  assign core_pend = bus.core_mem_op[0] && !lock_core_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    is_write_d   = is_write_q;
    cnt_d        = cnt_q;
    lock_wb_d    = lock_wb_q && bus.wbctrl_mem_op[0];
    lock_core_d  = lock_core_q && bus.core_mem_op[0];
    rr_d         = rr_q;
    csb_d        = 1'b1;
    web_d        = 1'b1;
    wmask_d      = '0;
    addr_d       = addr_q;
    din_d        = din_q;
    wb_done_d    = 1'b0;
    core_done_d  = 1'b0;
    wb_rdata_d   = wb_rdata_q;
    core_rdata_d = core_rdata_q;
    sel          = (wb_pend && core_pend) ? rr_q : core_pend;
    sel_write    = sel ? (bus.core_mem_op == 2'b11) : (bus.wbctrl_mem_op == 2'b11);
    sel_addr     = sel ? bus.core_mem_addr : bus.wbctrl_mem_addr;
    sel_data     = sel ? bus.core_mem_data : bus.wbctrl_mem_data;

    unique case (state_q)
      S_IDLE: begin
        if (wb_pend || core_pend) begin
          grant_d    = sel;
          is_write_d = sel_write;
          csb_d      = 1'b0;
          addr_d     = sel_addr;
          if (sel_write) begin
            web_d   = 1'b0;
            wmask_d = {MASK_W{1'b1}};
            din_d   = sel_data;
          end
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_d = '0;
        if (is_write_q) begin
          wb_done_d   = !grant_q;
          core_done_d = grant_q;
          state_d     = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == LAST_CNT) begin
          if (grant_q) core_rdata_d = bus.sram_dout0;
          else         wb_rdata_d   = bus.sram_dout0;
          wb_done_d   = !grant_q;
          core_done_d = grant_q;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        // Lock stops a requester still holding its op from being served twice
        if (grant_q) lock_core_d = 1'b1;
        else         lock_wb_d   = 1'b1;
        rr_d    = !grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign bus.sram_csb0       = csb_q;
  assign bus.sram_web0       = web_q;
  assign bus.sram_wmask0     = wmask_q;
  assign bus.sram_addr0      = addr_q;
  assign bus.sram_din0       = din_q;
  assign bus.mem_opdone      = wb_done_q;
  assign bus.core_mem_opdone = core_done_q;
  assign bus.sram_data       = wb_rdata_q;
  assign bus.core_sram_data  = core_rdata_q;
  assign bus.busy            = busy_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: cycle-by-cycle vector table on a READ_LATENCY=1 arbiter, plus a
// hand-written reset-during-wait sequence on a READ_LATENCY=3 arbiter.
module tb_sram_port_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam logic [31:0] X  = 32'hDEADBEEF;
  localparam logic [31:0] Y  = 32'h12345678;
  localparam logic [31:0] Z  = 32'hCAFEF00D;
  localparam logic [31:0] JUNK = 32'hBAD0BAD0;

  typedef struct {
    logic          rst;
    logic [1:0]    wop;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [1:0]    cop;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic [112:0]  exp;
  } vec_t;

  logic clk;
  logic rst1, rst3;
  int   n_tests, n_fail;
  vec_t vecs[$];

  sram_port_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus1();
  sram_port_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus3();

  sram_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(rst1), .bus(bus1));
  sram_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(rst3), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models: read data appears READ_LATENCY cycles after the strobe cycle
  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] mem3 [256];
  logic [DW-1:0] p1;
  logic [DW-1:0] p3 [3];

  always @(posedge clk) begin
    if (!bus1.sram_csb0 && !bus1.sram_web0)
      for (int b = 0; b < 4; b++)
        if (bus1.sram_wmask0[b]) mem1[bus1.sram_addr0][8*b +: 8] <= bus1.sram_din0[8*b +: 8];
    p1 <= (!bus1.sram_csb0 && bus1.sram_web0) ? mem1[bus1.sram_addr0] : JUNK;
  end

  always @(posedge clk) begin
    if (!bus3.sram_csb0 && !bus3.sram_web0)
      for (int b = 0; b < 4; b++)
        if (bus3.sram_wmask0[b]) mem3[bus3.sram_addr0][8*b +: 8] <= bus3.sram_din0[8*b +: 8];
    p3[0] <= (!bus3.sram_csb0 && bus3.sram_web0) ? mem3[bus3.sram_addr0] : JUNK;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign bus1.sram_dout0 = p1;
  assign bus3.sram_dout0 = p3[2];

  function automatic vec_t mk(
      input logic r, input logic [1:0] wop, input logic [7:0] wa, input logic [31:0] wd,
      input logic [1:0] cop, input logic [7:0] ca, input logic [31:0] cd,
      input logic csb, input logic web, input logic [3:0] wm, input logic [7:0] a0,
      input logic [31:0] d0, input logic mo, input logic co, input logic [31:0] sd,
      input logic [31:0] cdd, input logic bz);
    vec_t v;
    v.rst = r; v.wop = wop; v.wa = wa; v.wd = wd;
    v.cop = cop; v.ca = ca; v.cd = cd;
    v.exp = {csb, web, wm, a0, d0, mo, co, sd, cdd, bz};
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [112:0] obs1();
    return {bus1.sram_csb0, bus1.sram_web0, bus1.sram_wmask0, bus1.sram_addr0, bus1.sram_din0,
            bus1.mem_opdone, bus1.core_mem_opdone, bus1.sram_data, bus1.core_sram_data, bus1.busy};
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst1 = 1'b1;
    rst3 = 1'b1;
    bus1.wbctrl_mem_op = 2'b00; bus1.wbctrl_mem_addr = '0; bus1.wbctrl_mem_data = '0;
    bus1.core_mem_op   = 2'b00; bus1.core_mem_addr   = '0; bus1.core_mem_data   = '0;
    bus3.wbctrl_mem_op = 2'b00; bus3.wbctrl_mem_addr = '0; bus3.wbctrl_mem_data = '0;
    bus3.core_mem_op   = 2'b00; bus3.core_mem_addr   = '0; bus3.core_mem_data   = '0;
    mem3[7] = Z;

    // rst wop wa wd | cop ca cd | csb web wm a0 d0 | mo co sd cd busy
    vecs.push_back(mk(0,0,0,0, 0,0,0, 1,1,0,0,0, 0,0,0,0,0));      // idle after reset
    vecs.push_back(mk(0,3,5,X, 0,0,0, 1,1,0,0,0, 0,0,0,0,0));      // wb write at T
    vecs.push_back(mk(0,3,5,X, 0,0,0, 0,0,15,5,X, 0,0,0,0,1));
    vecs.push_back(mk(0,3,5,X, 0,0,0, 1,1,0,5,X, 1,0,0,0,1));
    vecs.push_back(mk(0,0,0,0, 0,0,0, 1,1,0,5,X, 0,0,0,0,0));
    vecs.push_back(mk(0,1,5,0, 0,0,0, 1,1,0,5,X, 0,0,0,0,0));      // wb read at T
    vecs.push_back(mk(0,1,5,0, 0,0,0, 0,1,0,5,X, 0,0,0,0,1));
    vecs.push_back(mk(0,1,5,0, 0,0,0, 1,1,0,5,X, 0,0,0,0,1));
    vecs.push_back(mk(0,1,5,0, 0,0,0, 1,1,0,5,X, 1,0,X,0,1));
    for (int i = 0; i < 5; i++)                                   // op held: no re-service
      vecs.push_back(mk(0,1,5,0, 0,0,0, 1,1,0,5,X, 0,0,X,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0, 1,1,0,5,X, 0,0,X,0,0));
    vecs.push_back(mk(0,1,5,0, 0,0,0, 1,1,0,5,X, 0,0,X,0,0));      // re-request after 00
    vecs.push_back(mk(0,1,5,0, 0,0,0, 0,1,0,5,X, 0,0,X,0,1));
    vecs.push_back(mk(0,1,5,0, 0,0,0, 1,1,0,5,X, 0,0,X,0,1));
    vecs.push_back(mk(0,1,5,0, 0,0,0, 1,1,0,5,X, 1,0,X,0,1));
    vecs.push_back(mk(0,0,0,0, 0,0,0, 1,1,0,5,X, 0,0,X,0,0));
    vecs.push_back(mk(0,0,0,0, 3,10,Y, 1,1,0,5,X, 0,0,X,0,0));     // core write
    vecs.push_back(mk(0,0,0,0, 3,10,Y, 0,0,15,10,Y, 0,0,X,0,1));
    vecs.push_back(mk(0,0,0,0, 3,10,Y, 1,1,0,10,Y, 0,1,X,0,1));
    vecs.push_back(mk(0,0,0,0, 3,10,Y, 1,1,0,10,Y, 0,0,X,0,0));
    vecs.push_back(mk(0,0,0,0, 2,10,Y, 1,1,0,10,Y, 0,0,X,0,0));    // reserved clears lock
    vecs.push_back(mk(0,0,0,0, 3,10,Y, 1,1,0,10,Y, 0,0,X,0,0));
    vecs.push_back(mk(0,0,0,0, 3,10,Y, 0,0,15,10,Y, 0,0,X,0,1));
    vecs.push_back(mk(0,0,0,0, 3,10,Y, 1,1,0,10,Y, 0,1,X,0,1));
    vecs.push_back(mk(0,2,5,X, 0,0,0, 1,1,0,10,Y, 0,0,X,0,0));     // reserved on wb
    vecs.push_back(mk(0,2,5,X, 0,0,0, 1,1,0,10,Y, 0,0,X,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0,0, 1,1,0,0,0, 0,0,0,0,0));      // reset
    vecs.push_back(mk(0,1,5,0, 1,10,0, 1,1,0,0,0, 0,0,0,0,0));     // simultaneous reads
    vecs.push_back(mk(0,1,5,0, 1,10,0, 0,1,0,5,0, 0,0,0,0,1));
    vecs.push_back(mk(0,1,5,0, 1,10,0, 1,1,0,5,0, 0,0,0,0,1));
    vecs.push_back(mk(0,1,5,0, 1,10,0, 1,1,0,5,0, 1,0,X,0,1));
    vecs.push_back(mk(0,0,0,0, 1,10,0, 1,1,0,5,0, 0,0,X,0,0));
    vecs.push_back(mk(0,0,0,0, 1,10,0, 0,1,0,10,0, 0,0,X,0,1));
    vecs.push_back(mk(0,0,0,0, 1,10,0, 1,1,0,10,0, 0,0,X,0,1));
    vecs.push_back(mk(0,0,0,0, 1,10,0, 1,1,0,10,0, 0,1,X,Y,1));
    vecs.push_back(mk(0,0,0,0, 0,0,0, 1,1,0,10,0, 0,0,X,Y,0));
    vecs.push_back(mk(0,1,5,0, 0,0,0, 1,1,0,10,0, 0,0,X,Y,0));     // wb alone, pointer -> core
    vecs.push_back(mk(0,1,5,0, 0,0,0, 0,1,0,5,0, 0,0,X,Y,1));
    vecs.push_back(mk(0,1,5,0, 0,0,0, 1,1,0,5,0, 0,0,X,Y,1));
    vecs.push_back(mk(0,1,5,0, 0,0,0, 1,1,0,5,0, 1,0,X,Y,1));
    vecs.push_back(mk(0,0,0,0, 0,0,0, 1,1,0,5,0, 0,0,X,Y,0));
    vecs.push_back(mk(0,1,5,0, 1,10,0, 1,1,0,5,0, 0,0,X,Y,0));     // both pending: core wins
    vecs.push_back(mk(0,1,5,0, 1,10,0, 0,1,0,10,0, 0,0,X,Y,1));
    vecs.push_back(mk(0,1,5,0, 1,10,0, 1,1,0,10,0, 0,0,X,Y,1));
    vecs.push_back(mk(0,1,5,0, 1,10,0, 1,1,0,10,0, 0,1,X,Y,1));
    vecs.push_back(mk(0,1,5,0, 0,0,0, 1,1,0,10,0, 0,0,X,Y,0));
    vecs.push_back(mk(0,1,5,0, 0,0,0, 0,1,0,5,0, 0,0,X,Y,1));
    vecs.push_back(mk(0,1,5,0, 0,0,0, 1,1,0,5,0, 0,0,X,Y,1));
    vecs.push_back(mk(0,1,5,0, 0,0,0, 1,1,0,5,0, 1,0,X,Y,1));
    vecs.push_back(mk(0,0,0,0, 0,0,0, 1,1,0,5,0, 0,0,X,Y,0));

    repeat (3) @(posedge clk);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst1 = vecs[i].rst;
      bus1.wbctrl_mem_op   = vecs[i].wop;
      bus1.wbctrl_mem_addr = vecs[i].wa;
      bus1.wbctrl_mem_data = vecs[i].wd;
      bus1.core_mem_op     = vecs[i].cop;
      bus1.core_mem_addr   = vecs[i].ca;
      bus1.core_mem_data   = vecs[i].cd;
      @(negedge clk);
      chk($sformatf("vec%0d", i), 128'(obs1()), 128'(vecs[i].exp));
    end

    // READ_LATENCY=3: reset asserted while waiting for read data
    @(posedge clk); #1 rst3 = 1'b0;
    @(posedge clk); #1;
    bus3.wbctrl_mem_op = 2'b01; bus3.wbctrl_mem_addr = 8'h07;
    @(negedge clk);
    chk("rl3_idle_at_T", 128'(bus3.busy), 128'(0));
    @(posedge clk); @(negedge clk);
    chk("rl3_strobe", 128'({bus3.sram_csb0, bus3.sram_web0, bus3.sram_addr0}), 128'({2'b01, 8'h07}));
    @(posedge clk);
    @(posedge clk); #1;
    chk("rl3_busy_in_wait", 128'({bus3.busy, bus3.mem_opdone}), 128'(2'b10));
    rst3 = 1'b1;
    bus3.wbctrl_mem_op = 2'b00;
    #1;
    chk("rl3_async_reset", 128'({bus3.sram_csb0, bus3.busy, bus3.mem_opdone, bus3.core_mem_opdone, bus3.sram_data}),
        128'({4'b1000, 32'h0}));
    @(posedge clk); #1 rst3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rl3_aborted%0d", k), 128'({bus3.sram_csb0, bus3.mem_opdone, bus3.busy}), 128'(3'b100));
      @(posedge clk); #1;
    end
    bus3.wbctrl_mem_op = 2'b01; bus3.wbctrl_mem_addr = 8'h07;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (k == 6) bus3.wbctrl_mem_op = 2'b00;
      end
      @(negedge clk);
      chk($sformatf("rl3_read_opdone_T+%0d", k), 128'({bus3.mem_opdone, bus3.core_mem_opdone}),
          128'({(k == 5), 1'b0}));
      if (k == 1) chk("rl3_read_strobe", 128'(bus3.sram_csb0), 128'(0));
      if (k == 5) chk("rl3_read_data", 128'(bus3.sram_data), 128'(Z));
    end
    @(posedge clk); @(negedge clk);
    chk("rl3_read_data_held", 128'({bus3.sram_data, bus3.busy}), 128'({Z, 1'b0}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Sits directly downstream of the Wishbone slave controller and arbitrates between its memory request port (`wbctrl_mem_*`) and the compute core's memory request port.
- Owns the single-port SRAM macro (OpenRAM-style, active-low strobes) and sequences one access at a time.
- Returns a one-cycle `opdone` pulse plus held read data to whichever requester was served.
- Guarantees that a requester still holding its op after completion is not served twice.

Parameters:
- AWIDTH, 8 (`KICP_SRAM_AWIDTH`), SRAM word-address width.
- DWIDTH, 32, data width.
- READ_LATENCY, 1, cycles from SRAM strobe cycle until `sram_dout0` valid (1..3).

Ports:
- clk  in  1  system clock (from slave controller `clk`)
- reset  in  1  asynchronous, active-high reset
- wbctrl_mem_op  in  2  Wishbone-side op: 01 read, 11 write, 00 none, 10 reserved (treated as none)
- wbctrl_mem_addr  in  AWIDTH  Wishbone-side word address
- wbctrl_mem_data  in  DWIDTH  Wishbone-side write data
- mem_opdone  out  1  Wishbone-side completion pulse
- sram_data  out  DWIDTH  Wishbone-side read data, held
- core_mem_op  in  2  core-side op, same encoding
- core_mem_addr  in  AWIDTH  core-side word address
- core_mem_data  in  DWIDTH  core-side write data
- core_mem_opdone  out  1  core-side completion pulse
- core_sram_data  out  DWIDTH  core-side read data, held
- busy  out  1  high whenever state is not IDLE
- sram_csb0  out  1  SRAM chip select, active low
- sram_web0  out  1  SRAM write enable, active low
- sram_wmask0  out  DWIDTH/8  byte write mask
- sram_addr0  out  AWIDTH  SRAM address
- sram_din0  out  DWIDTH  SRAM write data
- sram_dout0  in  DWIDTH  SRAM read data

Behaviour:

Reset (async, immediate):
- State IDLE, `csb0`=1, `web0`=1, `wmask0`=0, `addr0`=0, `din0`=0.
- Both opdone outputs 0, both read-data outputs 0, `busy`=0.
- Both release locks cleared, round-robin pointer = Wishbone side.
- Reset mid-access aborts the access with no opdone.

Outputs:
- All outputs are registered; none are combinational from inputs.

Pending request:
- A port is pending when its op is 01 or 11 and its release lock is clear.

States: IDLE -> ACCESS -> (WAIT) -> DONE -> IDLE.
- **IDLE:** if any port is pending, grant it and latch its op, addr and data. The registered SRAM controls take effect in the next cycle.
- **ACCESS (exactly 1 cycle):**
  - `csb0`=0, `addr0`=latched addr.
  - Write: `web0`=0, `wmask0`=all ones, `din0`=latched data; next state DONE.
  - Read: `web0`=1; next state WAIT.
- **WAIT (reads only):** count READ_LATENCY cycles with `csb0`=1. On the last count, capture `sram_dout0` into the granted port's read-data register, then go to DONE.
- **DONE (1 cycle):** granted port's opdone=1. Its read data is already valid in this cycle and is held until that port's next read completes. Set that port's release lock; flip the round-robin pointer to the other port; next state IDLE.

Release lock:
- Clears in any cycle the port's op is 00 or 10. This is required because the slave drops its op one cycle after seeing opdone.
- A port whose op stays non-zero is never re-served until the op has returned to 00.

Arbitration:
- Only one port pending: grant it.
- Both pending in the same IDLE cycle: grant the port named by the round-robin pointer.

Latency (request first visible in cycle T, in IDLE):
- Write: opdone during T+2.
- Read: opdone during T+2+READ_LATENCY.

Other rules:
- Inputs changing after the grant are ignored; the latched values are used.
- The non-granted port's opdone stays 0, and its read-data register is untouched.
- Address is passed through unchanged; no range checking.

Test Plan:
- **Wishbone write:** wb op=11, addr=0x05, data=0xDEADBEEF at T, op dropped the cycle after opdone -> `csb0`=0, `web0`=0, `addr0`=0x05, `din0`=0xDEADBEEF, `wmask0`=0xF during T+1; `mem_opdone`=1 during T+2 only.
- **Wishbone read:** read of addr 0x05, SRAM model returns 0xDEADBEEF, READ_LATENCY=1 -> `mem_opdone`=1 during T+3 with `sram_data`=0xDEADBEEF; value held afterwards.
- **Held op:** wb op held at 01 for 5 cycles after opdone -> no second `csb0` strobe. After op goes 00 then 01 again, exactly one new access occurs.
- **Simultaneous requests:** both ports request reads at the same T after reset -> Wishbone side served first, core side served next, starting at T+4. Repeating with both pending again -> core side wins.
- **Reset during WAIT:** reset asserted mid-read (READ_LATENCY=3) -> `csb0`=1, `busy`=0 and both opdone=0 immediately (asynchronously). After release, a new request completes normally.
- **Reserved op:** op=10 on either port -> no SRAM strobe and no opdone; the port's release lock is cleared.
